// File: rtl/async_packet_transmitter_pkg.sv
// Shared definitions for the packet transmitter: FSM state encoding,
// frame geometry and the bit-period computation.
package async_packet_transmitter_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP1 = 3'd3,
        STOP2 = 3'd4,
        GAP   = 3'd5
    } txState_t;

    // Frame geometry: 8 data bits, two stop bits (8N2)
    localparam int DataBits  = 8;
    localparam int StopBits  = 2;

    // One FIFO entry carries the byte plus its end-of-packet marker
    localparam int FifoWidth = DataBits + 1;

    // Clock cycles per bit, rounded to the nearest integer
    function automatic int bitClksCalc(input int clkFrequency, input int baud);
        return (clkFrequency + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/async_pkt_fifo.sv
// Byte FIFO for the packet transmitter. Show-ahead read: the head entry is
// always presented on rdData so the consumer can latch it on the pop edge.
module async_pkt_fifo #(
    parameter int Depth = 16,
    parameter int Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [Width-1:0] wrData,
    input  logic             rdEn,
    output logic [Width-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wrPtrReg;
    logic [PtrW-1:0]  rdPtrReg;
    logic [CntW-1:0]  countReg;
    logic             doWrite;
    logic             doRead;

    // Full blocks writes and empty blocks reads, so the pointers never cross
    assign doWrite = wrEn && !full;
    assign doRead  = rdEn && !empty;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtrReg] <= wrData;
        end
    end

    // Pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doWrite) begin
                wrPtrReg <= wrPtrReg + PtrW'(1);
            end
            if (doRead) begin
                rdPtrReg <= rdPtrReg + PtrW'(1);
            end
            case ({doWrite, doRead})
                2'b10:   countReg <= countReg + CntW'(1);
                2'b01:   countReg <= countReg - CntW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    assign rdData = mem[rdPtrReg];
    assign full   = (countReg == CntW'(Depth));
    assign empty  = (countReg == '0);

endmodule

// File: rtl/async_packet_transmitter.sv
// Packet-aware 8N2 serial transmitter. Bytes are queued with an
// end-of-packet marker; consecutive bytes of a packet go out back-to-back,
// and each packet is followed by a forced idle gap of GapBits bit-times.
module async_packet_transmitter
    import async_packet_transmitter_pkg::*;
#(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200,
    parameter int FifoDepth    = 16,
    parameter int GapBits      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DataBits-1:0] wr_data,
    input  logic                wr_last,
    output logic                full,
    output logic                TxD,
    output logic                busy,
    output logic                pkt_done,
    output logic                underrun
);

    localparam int BitClks = bitClksCalc(ClkFrequency, Baud);
    localparam int GapClks = GapBits * BitClks;
    // The gap is the longest interval timed, so its width covers every state
    localparam int CntW    = $clog2(GapClks);
    localparam int IdxW    = $clog2(DataBits);

    localparam logic [CntW-1:0] BitLast = CntW'(BitClks - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GapClks - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

    // Refuse to build with parameters the timing scheme cannot honour
    if (BitClks < 2) begin : gen_chk_bitclks
        $error("async_packet_transmitter: BitClks must be at least 2");
    end
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gen_chk_depth
        $error("async_packet_transmitter: FifoDepth must be a power of two, at least 2");
    end
    if (GapBits < 3) begin : gen_chk_gap
        $error("async_packet_transmitter: GapBits must be at least 3");
    end
    if (StopBits != 2) begin : gen_chk_stop
        $error("async_packet_transmitter: FSM implements exactly two stop bits");
    end

    txState_t             stateReg;
    txState_t             stateNext;
    logic [CntW-1:0]      cntReg;
    logic [CntW-1:0]      cntNext;
    logic [IdxW-1:0]      bitIdxReg;
    logic [IdxW-1:0]      bitIdxNext;
    logic [DataBits-1:0]  shiftReg;
    logic                 lastReg;

    logic                 fifoPop;
    logic [FifoWidth-1:0] fifoData;
    logic                 fifoEmpty;

    logic                 bitEnd;
    logic                 gapEnd;
    logic                 txdNext;
    logic                 pktDoneNext;
    logic                 underrunNext;

    async_pkt_fifo #(
        .Depth (FifoDepth),
        .Width (FifoWidth)
    ) fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (wr_en),
        .wrData ({wr_last, wr_data}),
        .rdEn   (fifoPop),
        .rdData (fifoData),
        .full   (full),
        .empty  (fifoEmpty)
    );

    assign bitEnd = (cntReg == BitLast);
    assign gapEnd = (cntReg == GapLast);

    // State register with the bit-period counter and data bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            cntReg    <= '0;
            bitIdxReg <= '0;
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            bitIdxReg <= bitIdxNext;
        end
    end

    // Frame byte: loaded on the pop edge, shifted out LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            lastReg  <= 1'b0;
        end else if (fifoPop) begin
            shiftReg <= fifoData[DataBits-1:0];
            lastReg  <= fifoData[DataBits];
        end else if ((stateReg == DATA) && bitEnd) begin
            shiftReg <= shiftReg >> 1;
        end
    end

    // Next-state logic; the counter restarts from zero on every state entry
    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg + CntW'(1);
        bitIdxNext = bitIdxReg;
        fifoPop    = 1'b0;
        case (stateReg)
            IDLE: begin
                cntNext = '0;
                if (!fifoEmpty) begin
                    stateNext = START;
                    fifoPop   = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext  = DATA;
                    cntNext    = '0;
                    bitIdxNext = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    cntNext = '0;
                    if (bitIdxReg == IdxLast) begin
                        stateNext = STOP1;
                    end else begin
                        bitIdxNext = bitIdxReg + IdxW'(1);
                    end
                end
            end
            STOP1: begin
                if (bitEnd) begin
                    stateNext = STOP2;
                    cntNext   = '0;
                end
            end
            STOP2: begin
                if (bitEnd) begin
                    cntNext = '0;
                    if (lastReg) begin
                        stateNext = GAP;
                    end else if (!fifoEmpty) begin
                        // Next byte of the same packet follows with no idle cycle
                        stateNext = START;
                        fifoPop   = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            GAP: begin
                if (gapEnd) begin
                    cntNext = '0;
                    if (!fifoEmpty) begin
                        stateNext = START;
                        fifoPop   = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Output decode: line level for the current state and end-of-phase pulses
    always_comb begin
        txdNext      = 1'b1;
        pktDoneNext  = 1'b0;
        underrunNext = 1'b0;
        case (stateReg)
            START:   txdNext      = 1'b0;
            DATA:    txdNext      = shiftReg[0];
            STOP2:   underrunNext = bitEnd && !lastReg && fifoEmpty;
            GAP:     pktDoneNext  = gapEnd;
            default: txdNext      = 1'b1;
        endcase
    end

    // Registered outputs; reset drives the line high at once, aborting any frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TxD      <= 1'b1;
            pkt_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            TxD      <= txdNext;
            pkt_done <= pktDoneNext;
            underrun <= underrunNext;
        end
    end

    assign busy = (stateReg != IDLE);

endmodule
